// File: rtl/demux_router_pkg.sv
// Default sizing constants shared by the demux router and its slots.
package demux_router_pkg;

    localparam int unsigned DEMUX_WIDTH  = 20;
    localparam int unsigned DEMUX_ADDR_W = 4;
    localparam int unsigned DEMUX_N_OUT  = 16;
    localparam int unsigned DEMUX_CNT_W  = 8;

endpackage

// File: rtl/demux_router_slot.sv
// One-entry output register with valid/ready handshake; a load on the same edge
// as a drain wins, so a busy channel sustains one beat per cycle.
module demux_router_slot
    import demux_router_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             can_acc
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign can_acc   = !valid_q || out_ready;

endmodule

// File: rtl/demux_router.sv
// Registered 1:N demultiplexer with per-channel backpressure, atomic broadcast
// and a saturating counter of beats dropped for an out-of-range address.
module demux_router
    import demux_router_pkg::*;
#(
    parameter int unsigned WIDTH  = DEMUX_WIDTH,
    parameter int unsigned ADDR_W = DEMUX_ADDR_W,
    parameter int unsigned N_OUT  = DEMUX_N_OUT,
    parameter int unsigned CNT_W  = DEMUX_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [CNT_W-1:0]       drop_cnt
);

    // One extra bit so N_OUT == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NOutExt = N_OUT[ADDR_W:0];

    logic [N_OUT-1:0] can_acc;
    logic [N_OUT-1:0] addr_hit;
    logic [N_OUT-1:0] load;
    logic             addr_ok;
    logic             fire;
    logic             drop;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign addr_ok = ({1'b0, in_addr} < NOutExt);

    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            addr_hit[i] = (in_addr == ADDR_W'(i));
        end
    end

    // Depends only on state, address and mode, never on in_valid or in_data.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (in_bcast) begin
                in_ready = &can_acc;
            end else if (addr_ok) begin
                in_ready = |(addr_hit & can_acc);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign fire = in_valid && in_ready;
    assign drop = fire && !in_bcast && !addr_ok;

    always_comb begin
        load = '0;
        if (fire) begin
            load = in_bcast ? '1 : addr_hit;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;

    for (genvar g = 0; g < int'(N_OUT); g++) begin : g_slot
        demux_router_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .out_data  (out_data[g*WIDTH +: WIDTH]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .can_acc   (can_acc[g])
        );
    end

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed beats feed per-channel expectation queues that a
// negedge monitor drains on every output handshake.
module tb_demux_router;
    import demux_router_pkg::*;

    localparam int W  = 20;
    localparam int NO = 16;
    localparam int N10 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [W-1:0]     in_data;
    logic [3:0]       in_addr;
    logic             in_bcast, in_valid, in_ready;
    logic [NO*W-1:0]  out_data;
    logic [NO-1:0]    out_valid, out_ready;
    logic [7:0]       drop_cnt;

    logic [W-1:0]     in_data10;
    logic [3:0]       in_addr10;
    logic             in_bcast10, in_valid10, in_ready10;
    logic [N10*W-1:0] out_data10;
    logic [N10-1:0]   out_valid10, out_ready10;
    logic [7:0]       drop_cnt10;

    demux_router u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    demux_router #(
        .N_OUT (N10)
    ) u_dut10 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data10),
        .in_addr   (in_addr10),
        .in_bcast  (in_bcast10),
        .in_valid  (in_valid10),
        .in_ready  (in_ready10),
        .out_data  (out_data10),
        .out_valid (out_valid10),
        .out_ready (out_ready10),
        .drop_cnt  (drop_cnt10)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [NO][$];

    task automatic chk(input string name, input logic [NO*W-1:0] act, input logic [NO*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sl(input int i);
        return out_data[i*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < NO; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_unexpected ch%0d: got %0h expected none", i, sl(i));
                    end else begin
                        chk($sformatf("drain_ch%0d", i), {300'b0, sl(i)}, {300'b0, exp_q[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NO*W-1:0] all5;
        int total;
        all5 = {16{20'h5A5A5}};

        rst = 1'b1; in_data = '0; in_addr = '0; in_bcast = 1'b0; in_valid = 1'b1;
        out_ready = '0;
        in_data10 = '0; in_addr10 = '0; in_bcast10 = 1'b0; in_valid10 = 1'b1;
        out_ready10 = '0;
        step();
        step();
        chk("rst_in_ready", {319'b0, in_ready}, '0);
        chk("rst_in_ready10", {319'b0, in_ready10}, '0);
        rst = 1'b0; in_valid = 1'b0; in_valid10 = 1'b0;
        chk("rst_out_valid", {304'b0, out_valid}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_drop_cnt", {312'b0, drop_cnt}, '0);

        // Unicast to slot 5, then hold under stall.
        in_addr = 4'd5; in_data = 20'hABCDE; in_valid = 1'b1;
        #1 chk("t1_in_ready", {319'b0, in_ready}, 1);
        exp_q[5].push_back(20'hABCDE);
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", {304'b0, out_valid}, 16'h0020);
        chk("t1_slice5", {300'b0, sl(5)}, 20'hABCDE);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_hold_valid", {304'b0, out_valid}, 16'h0020);
            chk("t1_hold_slice5", {300'b0, sl(5)}, 20'hABCDE);
        end

        // Backpressure on slot 5 does not block slot 6.
        in_addr = 4'd5; in_data = 20'h77777; in_valid = 1'b1;
        #1 chk("t2_blocked", {319'b0, in_ready}, 0);
        in_addr = 4'd6; in_data = 20'h12345;
        #1 chk("t2_other", {319'b0, in_ready}, 1);
        exp_q[6].push_back(20'h12345);
        step();
        in_valid = 1'b0;
        chk("t2_out_valid", {304'b0, out_valid}, 16'h0060);
        chk("t2_slice6", {300'b0, sl(6)}, 20'h12345);
        chk("t2_slice5", {300'b0, sl(5)}, 20'hABCDE);

        // Same-edge drain and reload on slot 3.
        in_addr = 4'd3; in_data = 20'h00011; in_valid = 1'b1;
        #1 chk("t3_first_ready", {319'b0, in_ready}, 1);
        exp_q[3].push_back(20'h00011);
        step();
        out_ready[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 20'(20'h00012 + k);
            #1 chk("t3_in_ready", {319'b0, in_ready}, 1);
            exp_q[3].push_back(20'(20'h00012 + k));
            step();
            chk("t3_valid", {319'b0, out_valid[3]}, 1);
            chk("t3_slice3", {300'b0, sl(3)}, 20'(20'h00012 + k));
        end
        in_valid = 1'b0;
        step();
        out_ready[3] = 1'b0;
        chk("t3_drained", {304'b0, out_valid}, 16'h0060);

        // Broadcast blocked by stalled slot 9, then atomic delivery.
        in_addr = 4'd9; in_data = 20'h09999; in_valid = 1'b1;
        #1 chk("t4_load9_ready", {319'b0, in_ready}, 1);
        exp_q[9].push_back(20'h09999);
        step();
        in_valid = 1'b0; out_ready = 16'hFDFF;
        step();
        out_ready = '0;
        chk("t4_only9", {304'b0, out_valid}, 16'h0200);
        in_bcast = 1'b1; in_data = 20'h5A5A5; in_addr = 4'd2; in_valid = 1'b1;
        #1 chk("t4_bcast_blocked", {319'b0, in_ready}, 0);
        step();
        chk("t4_no_change_valid", {304'b0, out_valid}, 16'h0200);
        chk("t4_no_change_slice9", {300'b0, sl(9)}, 20'h09999);
        chk("t4_no_change_slice2", {300'b0, sl(2)}, '0);
        out_ready = 16'h0200;
        #1 chk("t4_bcast_ready", {319'b0, in_ready}, 1);
        for (int i = 0; i < NO; i++) exp_q[i].push_back(20'h5A5A5);
        step();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
        chk("t4_all_valid", {304'b0, out_valid}, 16'hFFFF);
        chk("t4_all_data", out_data, all5);
        out_ready = '1;
        step();
        out_ready = '0;
        chk("t4_drained", {304'b0, out_valid}, '0);

        // Out-of-range address on a 10-channel instance.
        in_addr10 = 4'd12; in_data10 = 20'hFFFFF; in_valid10 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            chk("t5_in_ready", {319'b0, in_ready10}, 1);
            chk("t5_no_valid", {310'b0, out_valid10}, '0);
            chk("t5_drop_cnt", {312'b0, drop_cnt10}, (i > 255) ? 255 : i);
            step();
        end
        in_valid10 = 1'b0;
        chk("t5_saturated", {312'b0, drop_cnt10}, 255);
        chk("t5_final_no_valid", {310'b0, out_valid10}, '0);

        total = 0;
        for (int i = 0; i < NO; i++) total += exp_q[i].size();
        chk("sb_empty", {288'b0, 32'(total)}, '0);

        // Reset mid-operation with slots 0, 7, 15 full.
        in_data = 20'h0A0A0;
        for (int k = 0; k < 3; k++) begin
            in_addr = (k == 0) ? 4'd0 : (k == 1) ? 4'd7 : 4'd15;
            in_valid = 1'b1;
            #1 chk("t6_load_ready", {319'b0, in_ready}, 1);
            exp_q[in_addr].push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        chk("t6_full", {304'b0, out_valid}, 16'h8081);
        rst = 1'b1; in_valid = 1'b1; in_addr = 4'd2;
        #1 chk("t6_rst_in_ready", {319'b0, in_ready}, 0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < NO; i++) exp_q[i].delete();
        chk("t6_out_valid", {304'b0, out_valid}, '0);
        chk("t6_out_data", out_data, '0);
        chk("t6_drop_cnt10", {312'b0, drop_cnt10}, '0);
        chk("t6_drop_cnt", {312'b0, drop_cnt}, '0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
